// File: rtl/dsc_op_sequencer.sv
// Runs one DSC core operation per request: latch operands, clear core, enable until
// op_finished or the cycle budget is spent, then return result and enable-cycle count.
module dsc_op_sequencer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_INPUTS = 2,
   parameter int unsigned CNT_WIDTH  = 17
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [CNT_WIDTH-1:0]                 cfg_cycle_limit,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     in_data,
   output logic                                 core_rst,
   output logic                                 core_en,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0]     core_data_in,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     core_data_out,
   input  logic                                 core_op_finished,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0]     out_data,
   output logic [CNT_WIDTH-1:0]                 out_cycles,
   output logic                                 out_truncated,
   output logic                                 busy
);

   typedef enum logic [2:0] {StIdle, StClear, StRun, StCapture, StDone} state_e;

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   state_e               state;
   logic [CNT_WIDTH-1:0] limit;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 limit_hit;
   logic                 cnt_sat;
   logic                 run_done;

   // cnt_inc is the 1-based index of the current RUN cycle.
   assign cnt_inc   = cnt + CntOne;
   assign limit_hit = (limit != '0) && (cnt_inc == limit);
   assign cnt_sat   = &cnt_inc;
   assign run_done  = core_op_finished || limit_hit || cnt_sat;

   // Outputs are set on the transition into the state that owns them, so every
   // output is a flop and nothing combinational reaches a port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= StIdle;
         limit         <= '0;
         cnt           <= '0;
         core_data_in  <= '0;
         out_data      <= '0;
         out_cycles    <= '0;
         out_truncated <= 1'b0;
         out_valid     <= 1'b0;
         in_ready      <= 1'b1;
         core_rst      <= 1'b1;
         core_en       <= 1'b0;
         busy          <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid && in_ready) begin
                  core_data_in <= in_data;
                  limit        <= cfg_cycle_limit;
                  cnt          <= '0;
                  in_ready     <= 1'b0;
                  busy         <= 1'b1;
                  state        <= StClear;
               end
            end
            StClear: begin
               core_rst <= 1'b0;
               core_en  <= 1'b1;
               state    <= StRun;
            end
            StRun: begin
               cnt <= cnt_inc;
               if (run_done) begin
                  core_en       <= 1'b0;
                  // A finish in the same cycle as a budget stop still counts as natural.
                  out_truncated <= !core_op_finished;
                  state         <= StCapture;
               end
            end
            StCapture: begin
               out_data   <= core_data_out;
               out_cycles <= cnt;
               out_valid  <= 1'b1;
               state      <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  core_rst  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: begin
               core_en   <= 1'b0;
               core_rst  <= 1'b1;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Directed bench for dsc_op_sequencer with a behavioural core model; a second
// instance with a 4-bit counter exercises counter saturation.
module tb_dsc_op_sequencer;

   localparam int unsigned DW  = 8;
   localparam int unsigned NI  = 2;
   localparam int unsigned CW  = 17;
   localparam int unsigned CWS = 4;
   localparam int unsigned PW  = NI * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [CW-1:0] cfg;
   logic          in_valid, in_ready;
   logic [PW-1:0] in_data;
   logic          core_rst, core_en;
   logic [PW-1:0] core_data_in, core_data_out;
   logic          core_op_finished;
   logic          out_valid, out_ready;
   logic [PW-1:0] out_data;
   logic [CW-1:0] out_cycles;
   logic          out_truncated, busy;

   logic           in_valid_s, in_ready_s;
   logic [PW-1:0]  in_data_s;
   logic           core_rst_s, core_en_s;
   logic [PW-1:0]  core_data_in_s;
   logic           out_valid_s, out_ready_s;
   logic [PW-1:0]  out_data_s;
   logic [CWS-1:0] out_cycles_s;
   logic           out_truncated_s, busy_s;

   dsc_op_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_cycle_limit(cfg),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .core_rst(core_rst), .core_en(core_en), .core_data_in(core_data_in),
      .core_data_out(core_data_out), .core_op_finished(core_op_finished),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_cycles(out_cycles), .out_truncated(out_truncated), .busy(busy)
   );

   dsc_op_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .CNT_WIDTH(CWS)) dut_s (
      .clk(clk), .rst_n(rst_n), .cfg_cycle_limit(4'd0),
      .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
      .core_rst(core_rst_s), .core_en(core_en_s), .core_data_in(core_data_in_s),
      .core_data_out(16'hABCD), .core_op_finished(1'b0),
      .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
      .out_cycles(out_cycles_s), .out_truncated(out_truncated_s), .busy(busy_s)
   );

   // Core model: counts enable cycles since its last reset; finishes in enable cycle fin_at.
   logic [16:0] en_cnt, en_cnt_s, fin_at;
   logic [15:0] data_base;
   logic        data_inc;

   always @(posedge clk) begin
      if (core_rst) en_cnt <= '0;
      else if (core_en) en_cnt <= en_cnt + 17'd1;
      if (core_rst_s) en_cnt_s <= '0;
      else if (core_en_s) en_cnt_s <= en_cnt_s + 17'd1;
   end

   assign core_op_finished = core_en && (fin_at != 0) && (en_cnt + 17'd1 == fin_at);
   assign core_data_out    = data_base + (data_inc ? en_cnt[15:0] : 16'h0);

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Returns c0 = cycle count including the accepting edge E0; leaves us at a negedge.
   task automatic accept(input string tag, input logic [CW-1:0] lim, input logic [PW-1:0] d,
                         output int unsigned c0);
      @(negedge clk);
      cfg      = lim;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      c0       = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int unsigned max, output int unsigned c1);
      for (int i = 0; i < max && !out_valid; i++) @(negedge clk);
      if (!out_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
      c1 = cyc;
   endtask

   task automatic out_hs(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [CW-1:0] lim, input logic [16:0] fin,
                         input logic [15:0] base, input logic inc, input int unsigned n,
                         input logic [15:0] exp_data, input logic exp_trunc);
      int unsigned c0, c1;
      fin_at    = fin;
      data_base = base;
      data_inc  = inc;
      accept(tag, lim, 16'h1357, c0);
      wait_out(tag, n + 20, c1);
      // out_valid becomes visible just before edge E0+N+3, the first edge to sample it.
      check({tag, "_lat"}, c1 - c0 + 1, n + 3);
      check({tag, "_data"}, 32'(out_data), 32'(exp_data));
      check({tag, "_cycles"}, 32'(out_cycles), n);
      check({tag, "_trunc"}, 32'(out_truncated), 32'(exp_trunc));
      check({tag, "_en_cnt"}, 32'(en_cnt), n);
      out_hs(tag);
   endtask

   int unsigned c0, c1, seen;

   initial begin
      rst_n = 1'b0; cfg = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid_s = 1'b0; in_data_s = '0; out_ready_s = 1'b0;
      fin_at = '0; data_base = '0; data_inc = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_core_en", 32'(core_en), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cycles", 32'(out_cycles), 32'd0);
      check("rst_data_in", 32'(core_data_in), 32'd0);
      rst_n = 1'b1;

      // 1: unlimited, core finishes in enable cycle 300
      fin_at = 17'd300; data_base = 16'h2000; data_inc = 1'b0;
      accept("t1", '0, 16'h8040, c0);
      check("t1_core_data_in", 32'(core_data_in), 32'h8040);
      check("t1_clear_rst", 32'(core_rst), 32'd1);
      check("t1_clear_en", 32'(core_en), 32'd0);
      wait_out("t1", 320, c1);
      check("t1_lat", c1 - c0 + 1, 32'd303);
      check("t1_data", 32'(out_data), 32'h2000);
      check("t1_cycles", 32'(out_cycles), 32'd300);
      check("t1_trunc", 32'(out_truncated), 32'd0);
      check("t1_en_cnt", 32'(en_cnt), 32'd300);
      out_hs("t1");

      // 2: budget 100, no finish; data captured is the model value after 100 enables
      run_op("t2", 17'd100, 17'd0, 16'h1100, 1'b1, 100, 16'h1164, 1'b1);
      // 3: finish coincides with budget, then a one-cycle budget
      run_op("t3a", 17'd50, 17'd50, 16'h0505, 1'b0, 50, 16'h0505, 1'b0);
      run_op("t3b", 17'd1, 17'd0, 16'h0077, 1'b0, 1, 16'h0077, 1'b1);

      // 4: cfg change mid-RUN ignored; back-pressure holds results, pending input waits
      fin_at = 17'd40; data_base = 16'h4444; data_inc = 1'b0;
      accept("t4", '0, 16'h2222, c0);
      repeat (2) @(negedge clk);
      cfg = 17'd5;
      wait_out("t4", 60, c1);
      check("t4_cycles", 32'(out_cycles), 32'd40);
      check("t4_trunc", 32'(out_truncated), 32'd0);
      in_valid = 1'b1; in_data = 16'hBEEF; cfg = '0; fin_at = 17'd3;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         check("t4_hold_in_ready", 32'(in_ready), 32'd0);
         check("t4_hold_data", 32'(out_data), 32'h4444);
         check("t4_hold_cycles", 32'(out_cycles), 32'd40);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t4_hs_busy", 32'(busy), 32'd0);
      check("t4_hs_in_ready", 32'(in_ready), 32'd1);
      check("t4_hs_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check("t4_acc_busy", 32'(busy), 32'd1);
      check("t4_acc_data_in", 32'(core_data_in), 32'hBEEF);
      wait_out("t4b", 20, c1);
      check("t4b_cycles", 32'(out_cycles), 32'd3);
      check("t4b_trunc", 32'(out_truncated), 32'd0);
      out_hs("t4b");

      // 5: reset during RUN cycle 20 aborts the op
      fin_at = '0;
      accept("t5", '0, 16'h0101, c0);
      for (int i = 0; i < 20 && !core_en; i++) @(negedge clk);
      repeat (19) @(negedge clk);
      check("t5_pre_en_cnt", 32'(en_cnt), 32'd19);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t5_core_en", 32'(core_en), 32'd0);
      check("t5_core_rst", 32'(core_rst), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_cycles", 32'(out_cycles), 32'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      check("t5_no_stale", seen, 32'd0);

      // 6: 4-bit counter saturates at 15 enable cycles
      @(negedge clk);
      in_valid_s = 1'b1; in_data_s = 16'h1234;
      @(negedge clk);
      in_valid_s = 1'b0;
      check("t6_data_in", 32'(core_data_in_s), 32'h1234);
      for (int i = 0; i < 40 && !out_valid_s; i++) @(negedge clk);
      check("t6_valid", 32'(out_valid_s), 32'd1);
      check("t6_cycles", 32'(out_cycles_s), 32'd15);
      check("t6_trunc", 32'(out_truncated_s), 32'd1);
      check("t6_en_cnt", 32'(en_cnt_s), 32'd15);
      check("t6_data", 32'(out_data_s), 32'hABCD);
      out_ready_s = 1'b1;
      @(negedge clk);
      out_ready_s = 1'b0;
      check("t6_hs_valid", 32'(out_valid_s), 32'd0);
      check("t6_hs_busy", 32'(busy_s), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dsc_op_sequencer.md
Name: dsc_op_sequencer

Overview:
Controller that runs one DSC `core` operation at a time on behalf of an upstream requester. It accepts an operand vector over a valid/ready handshake, clears the core and loads the operands, then enables the core. The operation ends on the core's `op_finished` or when a programmable cycle budget runs out (early termination for accuracy/latency trade-off). It then captures the result and enable-cycle count and returns them over a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, width of each operand
NUM_INPUTS, 2, number of operands per operation
CNT_WIDTH, 17, width of the enable-cycle counter and cycle budget

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
cfg_cycle_limit  in  CNT_WIDTH  cycle budget; 0 = no limit (run to op_finished)
in_valid  in  1  operand vector valid
in_ready  out  1  sequencer can accept operands
in_data  in  NUM_INPUTS*DATA_WIDTH  packed operands, operand i at bits [i*DATA_WIDTH +: DATA_WIDTH]
core_rst  out  1  core reset, active-high
core_en  out  1  core enable
core_data_in  out  NUM_INPUTS*DATA_WIDTH  latched operands to core
core_data_out  in  NUM_INPUTS*DATA_WIDTH  core result
core_op_finished  in  1  core done indication
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  NUM_INPUTS*DATA_WIDTH  captured core_data_out
out_cycles  out  CNT_WIDTH  number of cycles core_en was high
out_truncated  out  1  1 = ended by budget or counter saturation, not op_finished
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All output registers cleared: core_data_in, out_data, out_cycles, out_truncated=0, out_valid=0.
  - core_rst=1, core_en=0, in_ready=1.
  - Reset mid-operation aborts it; no result is produced.
- FSM states: IDLE, CLEAR, RUN, CAPTURE, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1, core_rst=1, core_en=0.
  - On in_valid&&in_ready: latch in_data into core_data_in, latch cfg_cycle_limit into an internal limit register, clear the counter, go to CLEAR.
  - cfg_cycle_limit is ignored at all other times.
- CLEAR (exactly 1 cycle):
  - core_rst=1, core_en=0, operands stable.
  - Next state RUN.
- RUN:
  - core_rst=0, core_en=1; the counter increments every RUN cycle. Let j = the 1-based index of the current RUN cycle.
  - Exit to CAPTURE at the end of cycle j when any of these holds:
    - (a) core_op_finished=1 sampled in this cycle;
    - (b) limit!=0 and j==limit;
    - (c) j == 2^CNT_WIDTH-1 (saturation).
  - out_truncated = !(a). When (a) coincides with (b) or (c), (a) wins: truncated=0.
  - core_en is high for exactly j cycles; the counter never wraps.
- CAPTURE (1 cycle):
  - core_en=0, core_rst=0.
  - out_data <= core_data_out, out_cycles <= j.
  - Next state DONE.
- DONE:
  - out_valid=1, core_rst=0, core_en=0.
  - out_data, out_cycles and out_truncated are held stable until out_valid&&out_ready, then go to IDLE.
  - out_valid drops on the following edge.
  - in_ready=0 throughout DONE.
- Latency:
  - Handshake at edge E0; CLEAR during cycle E0..E1; RUN cycles 1..N.
  - out_valid first samples high at edge E0+N+3.
  - Minimum accept-to-accept interval with out_ready=1 is N+4 cycles.
- limit=1: exactly one enable cycle.
- The core is held in reset whenever the sequencer is IDLE or CLEAR.

Test Plan:
1. Defaults; limit=0, operands {0x40,0x80}; core model raises op_finished in enable cycle 300 with data 0x2000 → out_data=0x2000, out_cycles=300, out_truncated=0, out_valid at E0+303, core_en high for exactly 300 cycles.
2. limit=100; op_finished never asserted → core_en high exactly 100 cycles, out_cycles=100, out_truncated=1, out_data=core_data_out sampled in CAPTURE.
3. limit=50; op_finished asserted in enable cycle 50 → out_cycles=50, out_truncated=0. Repeat with limit=1 → out_cycles=1, truncated=1.
4. out_ready held low 10 cycles after out_valid → out_valid, out_data, out_cycles stable; in_ready=0; a pending in_valid is not accepted until one cycle after the output handshake. Change cfg_cycle_limit mid-RUN → no effect on the current op.
5. rst_n low for one edge at RUN cycle 20 → next cycle core_en=0, core_rst=1, busy=0, in_ready=1, out_valid=0; no stale result appears afterwards.
6. CNT_WIDTH=4, limit=0, op_finished never → stop after 15 enable cycles, out_cycles=15, out_truncated=1.
